// File: rtl/audio_pwm_feeder.sv
// Purpose : buffers signed PCM samples in a 4-deep FIFO, pops one per sample period and
//           converts the current sample to an unsigned PWM level, updated once per PWM period.
// Latency : a pop lands in cur_sample on the terminal count; the level reflects it at the next
//           period tick, visible one cycle after that tick together with period_start.
// Backpressure: sample_ready is registered and drops when the FIFO holds 4 entries. It does not
//           anticipate a same-cycle pop.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   sample/sample_valid   - 16-bit signed PCM input with valid/ready handshake
//   sample_ready          - FIFO has room (registered)
//   mute                  - force midscale output, sampled at each level update
//   underflow_clr         - clears the sticky underflow flag (a same-cycle set wins)
//   pwm_level             - unsigned WIDTH-bit level to the PWM stage
//   period_start          - one-cycle pulse when a new pwm_level is presented
//   fifo_count            - FIFO occupancy, 0..4
//   underflow             - sticky flag, set when a sample pop finds the FIFO empty
//
// Optional feature: define AUDIO_PWM_FEEDER_NOISE_SHAPE_EN to enable first-order error feedback.

module audio_pwm_feeder #(
  parameter int WIDTH      = 4,
  parameter int SAMPLE_DIV = 672
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      sample,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             mute,
  input  logic             underflow_clr,
  output logic [WIDTH-1:0] pwm_level,
  output logic             period_start,
  output logic [2:0]       fifo_count,
  output logic             underflow
);

  localparam int          S    = 16 - WIDTH;
  localparam logic [15:0] TERM = 16'(SAMPLE_DIV - 1);

  logic [15:0]      fifo_mem [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [15:0]      sample_cnt;
  logic [WIDTH-1:0] period_cnt;
  logic [15:0]      cur_sample;

  logic             push;
  logic             term;
  logic             pop;
  logic             tick;
  logic [2:0]       count_next;
  logic [15:0]      u;
  logic [WIDTH-1:0] level_next;

  assign push = sample_valid & sample_ready;
  assign term = (sample_cnt == TERM);
  assign pop  = term & (fifo_count != 3'd0);
  assign tick = (period_cnt == {WIDTH{1'b1}});

  always_comb begin
    count_next = fifo_count;
    case ({push, pop})
      2'b10:   count_next = fifo_count + 3'd1;
      2'b01:   count_next = fifo_count - 3'd1;
      default: count_next = fifo_count;
    endcase
  end

  // Offset binary: flipping the sign bit maps -32768..32767 onto 0..65535.
  assign u = mute ? 16'h8000 : {~cur_sample[15], cur_sample[14:0]};

`ifdef AUDIO_PWM_FEEDER_NOISE_SHAPE_EN
  logic [S-1:0] err;
  logic [S-1:0] err_next;
  logic [16:0]  sum;

  assign sum = {1'b0, u} + {{(17-S){1'b0}}, err};

  // Carry out means the accumulated error pushed past full scale: pin the
  // level at maximum and drop the residue rather than wrapping to zero.
  always_comb begin
    level_next = sum[15:S];
    err_next   = sum[S-1:0];
    if (sum[16]) begin
      level_next = {WIDTH{1'b1}};
      err_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= '0;
    end else if (tick) begin
      err <= err_next;
    end
  end
`else
  // Plain truncation of an unsigned 16-bit value cannot exceed the maximum level.
  assign level_next = u[15:S];
`endif

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_mem[wr_ptr] <= sample;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= 2'd0;
      rd_ptr       <= 2'd0;
      fifo_count   <= 3'd0;
      sample_ready <= 1'b0;
      sample_cnt   <= 16'd0;
      period_cnt   <= '0;
      cur_sample   <= 16'd0;
      underflow    <= 1'b0;
      pwm_level    <= {1'b1, {(WIDTH-1){1'b0}}};
      period_start <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + 2'd1;
        cur_sample <= fifo_mem[rd_ptr];
      end
      fifo_count   <= count_next;
      sample_ready <= (count_next < 3'd4);

      sample_cnt <= term ? 16'd0 : sample_cnt + 16'd1;
      period_cnt <= period_cnt + WIDTH'(1);

      // An empty FIFO at terminal count leaves cur_sample as it was.
      if (term && (fifo_count == 3'd0)) begin
        underflow <= 1'b1;
      end else if (underflow_clr) begin
        underflow <= 1'b0;
      end

      // The level uses cur_sample as registered before this edge, so a pop on
      // the same edge only takes effect from the following tick.
      period_start <= tick;
      if (tick) begin
        pwm_level <= level_next;
      end
    end
  end

endmodule

// File: tb/tb_audio_pwm_feeder.sv
module tb_audio_pwm_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        mute;
  logic        underflow_clr;
  logic [3:0]  pwm_level;
  logic        period_start;
  logic [2:0]  fifo_count;
  logic        underflow;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  audio_pwm_feeder #(.WIDTH(4), .SAMPLE_DIV(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample        (sample),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .mute          (mute),
    .underflow_clr (underflow_clr),
    .pwm_level     (pwm_level),
    .period_start  (period_start),
    .fifo_count    (fifo_count),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle before sampling outputs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int e);
    while (cyc < e) step();
  endtask

  initial begin
    reset         = 1'b1;
    sample        = 16'h0000;
    sample_valid  = 1'b0;
    mute          = 1'b0;
    underflow_clr = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_level", 32'(pwm_level), 32'd8);
    chk("rst_pstart", 32'(period_start), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(sample_ready), 32'd0);
    chk("rst_uflow", 32'(underflow), 32'd0);

    reset = 1'b0;
    cyc   = 0;
    step();
    chk("rel_ready", 32'(sample_ready), 32'd1);
    chk("rel_count", 32'(fifo_count), 32'd0);
    chk("rel_uflow", 32'(underflow), 32'd0);
    chk("rel_level", 32'(pwm_level), 32'd8);

    // Full-scale positive then negative: pops at 64 and 128
    sample_valid = 1'b1;
    sample       = 16'h7FFF;
    step();
    sample       = 16'h8000;
    step();
    sample_valid = 1'b0;
    chk("two_pushed", 32'(fifo_count), 32'd2);

    goto(64);
    chk("pop1_count", 32'(fifo_count), 32'd1);
    chk("pop1_level_old", 32'(pwm_level), 32'd8);
    chk("pop1_pstart", 32'(period_start), 32'd1);
    goto(80);
    chk("max_level", 32'(pwm_level), 32'd15);
    goto(96);
    chk("max_level_sat", 32'(pwm_level), 32'd15);
    goto(128);
    chk("pop2_count", 32'(fifo_count), 32'd0);
    goto(144);
    chk("min_level", 32'(pwm_level), 32'd0);

    // Underflow at 192 with an empty FIFO
    goto(192);
    chk("uflow_set", 32'(underflow), 32'd1);
    chk("uflow_level_hold", 32'(pwm_level), 32'd0);
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;
    chk("uflow_clr", 32'(underflow), 32'd0);

    // Clear coincident with a new underflow at 256
    goto(255);
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;
    chk("uflow_set_wins", 32'(underflow), 32'd1);
    step();
    chk("uflow_sticky", 32'(underflow), 32'd1);
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;

    // Fill: valid held 5 cycles, only 4 accepted
    sample_valid = 1'b1;
    sample       = 16'h7FFF;
    repeat (4) step();
    chk("full_ready", 32'(sample_ready), 32'd0);
    chk("full_count", 32'(fifo_count), 32'd4);
    step();
    sample_valid = 1'b0;
    chk("full_count_hold", 32'(fifo_count), 32'd4);

    goto(320);
    chk("full_pop_count", 32'(fifo_count), 32'd3);
    goto(336);
    chk("queued_max", 32'(pwm_level), 32'd15);

    // Mute forces midscale
    goto(340);
    mute = 1'b1;
    goto(352);
    chk("mute_level", 32'(pwm_level), 32'd8);
    mute = 1'b0;
    goto(368);
    chk("unmute_level", 32'(pwm_level), 32'd15);

    // Push coinciding with a pop at count 3
    goto(383);
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("push_pop_count", 32'(fifo_count), 32'd3);

    // Mid-operation reset with an in-flight push
    goto(390);
    reset        = 1'b1;
    sample_valid = 1'b1;
    step();
    chk("mid_rst_level", 32'(pwm_level), 32'd8);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_ready", 32'(sample_ready), 32'd0);
    sample_valid = 1'b0;
    reset        = 1'b0;
    cyc          = 0;
    step();
    chk("mid_rel_count", 32'(fifo_count), 32'd0);
    chk("mid_rel_ready", 32'(sample_ready), 32'd1);

    // Small offset sample 0x0800 -> u = 0x8800, half an LSB above midscale
    sample_valid = 1'b1;
    sample       = 16'h0800;
    step();
    sample_valid = 1'b0;
    goto(80);
    chk("ns_t1_level", 32'(pwm_level), 32'd8);
    chk("ns_t1_pstart", 32'(period_start), 32'd1);
    step();
    chk("ns_pstart_low", 32'(period_start), 32'd0);
    goto(95);
    chk("ns_pstart_pre", 32'(period_start), 32'd0);
    goto(96);
    chk("ns_t2_pstart", 32'(period_start), 32'd1);
`ifdef AUDIO_PWM_FEEDER_NOISE_SHAPE_EN
    chk("ns_t2_level", 32'(pwm_level), 32'd9);
    goto(112);
    chk("ns_t3_level", 32'(pwm_level), 32'd8);
    goto(128);
    chk("ns_t4_level", 32'(pwm_level), 32'd9);
`else
    chk("ns_t2_level", 32'(pwm_level), 32'd8);
    goto(112);
    chk("ns_t3_level", 32'(pwm_level), 32'd8);
    goto(128);
    chk("ns_t4_level", 32'(pwm_level), 32'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/audio_pwm_feeder.md
AUDIO_PWM_FEEDER -- requirements
Module: audio_pwm_feeder

Interface
REQ-001 Parameter WIDTH, default 4: PWM level width; must equal the downstream PWM stage's WIDTH.
REQ-002 Parameter SAMPLE_DIV, default 672: clocks per audio sample (about 32 kHz at 21.477 MHz); legal range 2^WIDTH..65535.
REQ-003 clk  in  1: single clock; all logic on posedge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 sample  in  16: signed two's-complement mono PCM sample.
REQ-006 sample_valid  in  1: sample is presented this cycle.
REQ-007 sample_ready  out  1: FIFO can accept a sample; a push occurs when sample_valid and sample_ready are both 1.
REQ-008 mute  in  1: force silence, sampled at each level update.
REQ-009 underflow_clr  in  1: clears the underflow flag.
REQ-010 pwm_level  out  WIDTH: unsigned level driven to the PWM stage's din.
REQ-011 period_start  out  1: one-cycle pulse in the cycle pwm_level changes value.
REQ-012 fifo_count  out  3: number of entries in the FIFO, 0..4.
REQ-013 underflow  out  1: sticky flag; set when a sample pop finds the FIFO empty.

Function
REQ-014 The input buffer shall be a 4-entry FIFO; sample_ready = (fifo_count < 4), registered from current occupancy and not anticipating a same-cycle pop.
REQ-015 A push and a pop in the same cycle shall both take effect, leaving fifo_count unchanged.
REQ-016 The sample counter shall count 0..SAMPLE_DIV-1 and wrap; at terminal count, the head entry is popped into cur_sample.
REQ-017 If the FIFO is empty at terminal count, cur_sample holds its value and underflow is set.
REQ-018 If a set and underflow_clr occur in the same cycle, set shall win.
REQ-019 The period counter shall be WIDTH bits and free-running; a tick occurs when it equals 2^WIDTH-1.
REQ-020 On each tick, pwm_level and the error register shall update; the new value is visible the next cycle, coincident with period_start=1.
REQ-021 Offset conversion: u = sample with MSB inverted (unsigned 16-bit); if mute=1, u = 0x8000.
REQ-022 Quantisation with shift S = 16-WIDTH is defined under Configuration.
REQ-023 cur_sample updated by a pop shall be used from the next tick onward, never mid-computation.
REQ-024 pwm_level shall never wrap from maximum to 0; saturation is mandatory.

Reset
REQ-025 During reset: pwm_level = 2^(WIDTH-1) (midscale), period_start = 0, fifo_count = 0, sample_ready = 0, underflow = 0.
REQ-026 Reset shall also clear: error register = 0, cur_sample = 0, both counters = 0, FIFO pointers = 0.
REQ-027 After reset deasserts, sample_ready = 1 in the first cycle.
REQ-028 Reset asserted mid-operation shall discard FIFO contents and drop any in-flight push.

Configuration
REQ-029 Macro AUDIO_PWM_FEEDER_NOISE_SHAPE_EN defined: first-order error feedback.
- sum = u + err (17-bit).
- If sum >= 2^16: pwm_level = 2^WIDTH-1 and err = 0.
- Else: pwm_level = sum[15:S] and err = sum[S-1:0].
REQ-030 Macro undefined: pwm_level = u[15:S]; the error register is not instantiated.

Verification (WIDTH=4, SAMPLE_DIV=64 unless noted)
REQ-031 Reset sequence -> pwm_level=8, sample_ready=1 after release, fifo_count=0, underflow=0.
REQ-032 Push 0x7FFF then 0x8000 (macro off) -> pwm_level=15 after first pop plus one tick; 0 after second pop plus one tick.
REQ-033 Push 0x0800 (macro on) -> pwm_level alternates 8,9,8,9 on successive ticks; period_start pulses every 16 clocks.
REQ-034 sample_valid held for 5 cycles with no pop -> 4 accepted, sample_ready=0 after the 4th, fifo_count=4; simultaneous push at a pop with count=3 -> count stays 3.
REQ-035 No push across a terminal count -> underflow=1 and pwm_level unchanged; underflow_clr pulse -> 0; clear coincident with a new underflow -> stays 1.
REQ-036 mute=1 with 0x7FFF queued -> pwm_level=8; reset asserted with fifo_count=3 -> fifo_count=0 and pwm_level=8 next cycle.
